// File: rtl/vec_mem_requester.sv
// Load/store sequencer for the 16-bank vector data memory.
// Define LSU_BURST_EN for multi-beat bursts; otherwise every request is one beat.
module vec_mem_requester #(
  parameter int ADDR_W   = 18,
  parameter int LANES    = 16,
  parameter int READ_LAT = 2,
  parameter int LEN_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_vec,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [LANES-1:0][31:0]  wd_data,
  output logic                    rsp_valid,
  output logic                    rsp_last,
  output logic [LANES-1:0][31:0]  rsp_data,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_address,
  output logic                    mem_wren,
  output logic                    mem_vec_scalar,
  output logic [LANES-1:0][31:0]  mem_data,
  input  logic [LANES-1:0][31:0]  mem_q
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] req_step;
  logic [READ_LAT:0] tag_v;
  logic [READ_LAT:0] tag_l;
  logic              last_beat;
  logic              first_last;
  logic              unused_q;

  assign step     = mem_vec_scalar ? ADDR_W'(LANES) : ADDR_W'(1);
  assign req_step = req_vec ? ADDR_W'(LANES) : ADDR_W'(1);
  assign unused_q = ^mem_q;

`ifdef LSU_BURST_EN
  // rem counts beats still to be issued, including the current one
  logic [LEN_W:0] rem;

  assign last_beat  = (rem == (LEN_W+1)'(1));
  assign first_last = (req_len == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (req_valid)
            rem <= req_write ? {1'b0, req_len} + (LEN_W+1)'(1)
                             : {1'b0, req_len};
        S_LOAD:  rem <= rem - (LEN_W+1)'(1);
        S_STORE: if (wd_valid) rem <= rem - (LEN_W+1)'(1);
        default: rem <= rem;
      endcase
    end
  end
`else
  logic unused_len;

  assign last_beat  = 1'b1;
  assign first_last = 1'b1;
  assign unused_len = ^req_len;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      next_addr      <= '0;
      tag_v          <= '0;
      tag_l          <= '0;
      done           <= 1'b0;
      mem_address    <= '0;
      mem_wren       <= 1'b0;
      mem_vec_scalar <= 1'b0;
      mem_data       <= '0;
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      tag_v    <= {tag_v[READ_LAT-1:0], 1'b0};
      tag_l    <= {tag_l[READ_LAT-1:0], 1'b0};
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_vec_scalar <= req_vec;
            if (req_write) begin
              next_addr <= req_addr;
              state     <= S_STORE;
            end else begin
              // beat 0 goes out on the accepting edge
              mem_address <= req_addr;
              next_addr   <= req_addr + req_step;
              tag_v[0]    <= 1'b1;
              tag_l[0]    <= first_last;
              state       <= first_last ? S_DRAIN : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          mem_address <= next_addr;
          next_addr   <= next_addr + step;
          tag_v[0]    <= 1'b1;
          tag_l[0]    <= last_beat;
          if (last_beat) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // the output stage may still hold the final beat this cycle
          if (tag_v[READ_LAT-1:0] == '0) state <= S_IDLE;
        end
        S_STORE: begin
          if (wd_valid) begin
            mem_wren    <= 1'b1;
            mem_data    <= wd_data;
            mem_address <= next_addr;
            next_addr   <= next_addr + step;
            if (last_beat) state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign wd_ready  = (state == S_STORE);
  assign rsp_valid = tag_v[READ_LAT];
  assign rsp_last  = tag_l[READ_LAT];

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rsp_valid && (mem_vec_scalar || i == 0))
        rsp_data[i] = {16'h0000, mem_q[i][15:0]};
    end
  end

endmodule

// File: tb/tb_vec_mem_requester.sv
// Bench for vec_mem_requester: table vectors, random bursts, reset corners.
// Reference model computes beat addresses and response masks arithmetically.
module tb_vec_mem_requester;

  localparam int AW = 18;
  localparam int L  = 16;
  localparam int RL = 2;
  localparam int LW = 4;
`ifdef LSU_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic                req_vec;
  logic [AW-1:0]       req_addr;
  logic [LW-1:0]       req_len;
  logic                wd_valid;
  logic                wd_ready;
  logic [L-1:0][31:0]  wd_data;
  logic                rsp_valid;
  logic                rsp_last;
  logic [L-1:0][31:0]  rsp_data;
  logic                done;
  logic [AW-1:0]       mem_address;
  logic                mem_wren;
  logic                mem_vec_scalar;
  logic [L-1:0][31:0]  mem_data;
  logic [L-1:0][31:0]  mem_q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vec_mem_requester #(
    .ADDR_W(AW), .LANES(L), .READ_LAT(RL), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_vec(req_vec),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .done(done),
    .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_vec_scalar(mem_vec_scalar), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  typedef struct {
    bit          vec;
    logic [17:0] addr;
    logic [3:0]  len;
    logic [31:0] q;
    logic [17:0] e_a0;
    logic [31:0] e_l0;
    logic [31:0] e_l1;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic int beats(logic [3:0] len);
    return BURST ? int'(len) + 1 : 1;
  endfunction

  function automatic logic [17:0] beat_addr(logic [17:0] b, bit vec, int k);
    logic [17:0] r;
    r = b + 18'(k * (vec ? 16 : 1));
    return r;
  endfunction

  function automatic logic [511:0] exp_rsp(bit vec, logic [511:0] q);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < L; i++)
      if (vec || i == 0) r[i*32 +: 16] = q[i*32 +: 16];
    return r;
  endfunction

  function automatic logic [511:0] rand_lanes();
    logic [511:0] r;
    for (int i = 0; i < L; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_load(bit vec, logic [17:0] addr, logic [3:0] len,
                          logic [511:0] q, bit tbl, logic [17:0] e_a0,
                          logic [31:0] e_l0, logic [31:0] e_l1);
    int n;
    int idx;
    bit ve;
    n = beats(len);
    mem_q     = q;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_vec   = vec;
    req_addr  = addr;
    req_len   = len;
    chk("ld_accept_ready", req_ready, 1);
    tick();
    for (int cyc = 1; cyc <= n + RL + 1; cyc++) begin
      idx = cyc - 1 - RL;
      ve  = (idx >= 0) && (idx < n);
      chk("ld_rsp_valid", rsp_valid, ve);
      chk("ld_rsp_last", rsp_last, ve && (idx == n - 1));
      chk("ld_rsp_data", rsp_data, ve ? exp_rsp(vec, q) : '0);
      if (cyc <= n)
        chk("ld_addr", mem_address, beat_addr(addr, vec, cyc - 1));
      chk("ld_wren", mem_wren, 0);
      chk("ld_vs", mem_vec_scalar, vec);
      chk("ld_req_ready", req_ready, cyc == n + RL + 1);
      if (tbl && cyc == 1) chk("tbl_addr0", mem_address, e_a0);
      if (tbl && cyc == 1 + RL) begin
        chk("tbl_lane0", rsp_data[0], e_l0);
        chk("tbl_lane1", rsp_data[1], e_l1);
      end
      // junk requests while busy must be ignored
      if (cyc <= n + RL) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_vec   = ~vec;
        req_addr  = 18'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic run_store(bit vec, logic [17:0] addr, logic [3:0] len,
                           int mode);
    int n, k, wr, gap;
    bit prev_acc, acc, exp_done, next_done, stall, fin;
    logic [511:0] prev_data;
    n = beats(len);
    k = 0; wr = 0; gap = 0;
    prev_acc = 0; exp_done = 0; fin = 0;
    prev_data = '0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_vec   = vec;
    req_addr  = addr;
    req_len   = len;
    tick();
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      chk("st_wren", mem_wren, prev_acc);
      if (prev_acc) begin
        chk("st_addr", mem_address, beat_addr(addr, vec, wr));
        chk("st_data", mem_data, prev_data);
        chk("st_vs", mem_vec_scalar, vec);
        wr++;
      end
      chk("st_done", done, exp_done);
      chk("st_wd_ready", wd_ready, k < n);
      chk("st_req_ready", req_ready, exp_done);
      chk("st_rsp_valid", rsp_valid, 0);
      if (exp_done) begin
        fin = 1;
        wd_valid = 1'b0;
        break;
      end
      next_done = prev_acc && (wr == n);
      acc = 0;
      wd_data = rand_lanes();
      if (k < n) begin
        stall = 0;
        if (mode == 1) stall = ($urandom_range(0, 3) == 0);
        if (mode == 2 && k == 1 && gap < 2) begin
          stall = 1;
          gap++;
        end
        wd_valid = !stall;
        if (!stall) begin
          acc = 1;
          k++;
          prev_data = wd_data;
        end
      end else begin
        wd_valid = 1'($urandom_range(0, 1));
      end
      prev_acc = acc;
      exp_done = next_done;
      tick();
    end
    if (!fin) chk("st_timeout", 0, 1);
  endtask

  task automatic run_rst_load(logic [3:0] len);
    int n;
    n = beats(len);
    mem_q     = rand_lanes();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_vec   = 1'b1;
    req_addr  = 18'($urandom);
    req_len   = len;
    tick();
    req_valid = 1'b0;
    for (int cyc = 1; cyc < n; cyc++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ld_ready", req_ready, 1);
    for (int i = 0; i < RL + 3; i++) begin
      chk("rst_ld_rsp_valid", rsp_valid, 0);
      chk("rst_ld_rsp_data", rsp_data, '0);
      tick();
    end
  endtask

  task automatic run_rst_store();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_vec   = 1'b1;
    req_addr  = 18'h00080;
    req_len   = 4'd3;
    tick();
    req_valid = 1'b0;
    wd_valid  = 1'b1;
    wd_data   = rand_lanes();
    rst       = 1'b1;
    tick();
    rst      = 1'b0;
    wd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_st_wren", mem_wren, 0);
      chk("rst_st_done", done, 0);
      chk("rst_st_ready", req_ready, 1);
      tick();
    end
  endtask

  initial begin
    vec_t tbl [4];
    logic [511:0] q;
    tbl[0] = '{1'b1, 18'h00100, 4'd0, 32'hABCD1234, 18'h00100,
               32'h00001234, 32'h00001234};
    tbl[1] = '{1'b0, 18'h00200, 4'd0, 32'h0000FFFF, 18'h00200,
               32'h0000FFFF, 32'h00000000};
    tbl[2] = '{1'b1, 18'h3FFF8, 4'd3, 32'h5555AAAA, 18'h3FFF8,
               32'h0000AAAA, 32'h0000AAAA};
    tbl[3] = '{1'b0, 18'h3FFFF, 4'd7, 32'h12345678, 18'h3FFFF,
               32'h00005678, 32'h00000000};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_vec   = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    mem_q     = {L{32'hDEADBEEF}};
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wd_ready", wd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_done", done, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_vs", mem_vec_scalar, 0);
    chk("rst_mem_data", mem_data, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      q = {L{tbl[i].q}};
      run_load(tbl[i].vec, tbl[i].addr, tbl[i].len, q, 1'b1,
               tbl[i].e_a0, tbl[i].e_l0, tbl[i].e_l1);
    end

    run_store(1'b0, 18'h00040, 4'd1, 2);
    run_store(1'b1, 18'h3FFF0, 4'd2, 0);
    run_rst_load(4'd1);
    run_rst_load(4'd0);
    run_rst_store();

    for (int i = 0; i < 24; i++) begin
      run_load(1'($urandom_range(0, 1)), 18'($urandom),
               4'($urandom), rand_lanes(), 1'b0, '0, '0, '0);
      run_store(1'($urandom_range(0, 1)), 18'($urandom),
                4'($urandom), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
